// File: rtl/matriz_led_pkg.sv
// Shared constants and types for the 5x7 LED matrix column scanner.
// Contents:
//   NCOL/NROW/CODE_W  matrix geometry and pattern width
//   modo_t            display mode (OFF, MAP, MAP_ATK) derived from ch7/ch6
//   col_t             column index states COL0..COL4
//   CS_*              bit positions inside col_sel, shared with the column decoder
//   col_of()          extracts the 7 row bits of one column from a pattern
package matriz_led_pkg;

  localparam int NCOL   = 5;
  localparam int NROW   = 7;
  localparam int CODE_W = NCOL * NROW;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_MAP,
    MODE_MAP_ATK
  } modo_t;

  typedef enum logic [2:0] {
    COL0 = 3'd0,
    COL1 = 3'd1,
    COL2 = 3'd2,
    COL3 = 3'd3,
    COL4 = 3'd4
  } col_t;

  // The decoder expects the column index MSB-first on the low bits.
  localparam int CS_IDX2  = 0;
  localparam int CS_IDX1  = 1;
  localparam int CS_IDX0  = 2;
  localparam int CS_BLANK = 3;

  // Column c occupies bits [7c+6:7c]; row r is bit 7c+r.
  function automatic logic [NROW-1:0] col_of(input logic [CODE_W-1:0] code, input col_t c);
    logic [CODE_W-1:0] sh;
    sh = code >> (NROW * int'(c));
    return sh[NROW-1:0];
  endfunction

endpackage

// File: rtl/matriz_led_varredura_if.sv
// Bundle between the scan sequencer and its environment.
//   master : drives ch6, ch7, codigo_map, codigo_atk, load
//   slave  : drives load_ack, col_sel, linhas, ativo, frame_start
interface matriz_led_varredura_if;

  logic                              ch6;
  logic                              ch7;
  logic [matriz_led_pkg::CODE_W-1:0] codigo_map;
  logic [matriz_led_pkg::CODE_W-1:0] codigo_atk;
  logic                              load;
  logic                              load_ack;
  logic [3:0]                        col_sel;
  logic [matriz_led_pkg::NROW-1:0]   linhas;
  logic                              ativo;
  logic                              frame_start;

  modport master (
    output ch6, ch7, codigo_map, codigo_atk, load,
    input  load_ack, col_sel, linhas, ativo, frame_start
  );

  modport slave (
    input  ch6, ch7, codigo_map, codigo_atk, load,
    output load_ack, col_sel, linhas, ativo, frame_start
  );

endinterface

// File: rtl/matriz_led_prescaler.sv
// Column-slot prescaler: counts 0..DIV-1 and wraps.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   slot_end_o   high during the last cycle of a slot (cnt == DIV-1)
//   in_blank_o   high while cnt < BLANK (rows must be dark)
module matriz_led_prescaler #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end_o,
  output logic in_blank_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign slot_end_o = (cnt_q == CW'(DIV - 1));
  assign in_blank_o = (32'(cnt_q) < BLANK);
  assign cnt_d      = slot_end_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matriz_led_varredura.sv
// Column-scan sequencer for the 5x7 LED matrix.
// Steps the column index 0..4 once per prescaler slot, drives the 7 row lines
// for that column and double-buffers the map/attack patterns so a new pattern
// only becomes visible at a frame boundary.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus (slave) ch6/ch7 mode, codigo_map/codigo_atk patterns, load/load_ack
//               handshake, col_sel/linhas/ativo/frame_start to the decoder
// Optional feature: define MATRIZ_BLINK_EN to blink the attack layer every
// BLINK_FRAMES frames; otherwise the attack layer is shown continuously.
module matriz_led_varredura
  import matriz_led_pkg::*;
#(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK        = 16,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matriz_led_varredura_if.slave  bus
);

  logic slot_end, in_blank;

  matriz_led_prescaler #(.DIV(DIV), .BLANK(BLANK)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_end_o (slot_end),
    .in_blank_o (in_blank)
  );

  // Column index FSM
  col_t idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= COL0;
    else        idx_q <= idx_d;
  end

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      unique case (idx_q)
        COL0:    idx_d = COL1;
        COL1:    idx_d = COL2;
        COL2:    idx_d = COL3;
        COL3:    idx_d = COL4;
        default: idx_d = COL0;
      endcase
    end
  end

  logic boundary, commit;
  assign boundary = slot_end && (idx_q == COL4);

  // Shadow/active buffers
  logic [CODE_W-1:0] shadow_map_q, shadow_map_d, shadow_atk_q, shadow_atk_d;
  logic [CODE_W-1:0] active_map_q, active_map_d, active_atk_q, active_atk_d;
  logic              pend_q, pend_d;

  assign commit = boundary && pend_q;

  // A load coinciding with a commit lands in the shadow after the old
  // shadow moves to active, so it stays pending for the next boundary.
  always_comb begin
    shadow_map_d = shadow_map_q;
    shadow_atk_d = shadow_atk_q;
    active_map_d = active_map_q;
    active_atk_d = active_atk_q;
    pend_d       = pend_q;
    if (commit) begin
      active_map_d = shadow_map_q;
      active_atk_d = shadow_atk_q;
      pend_d       = 1'b0;
    end
    if (bus.load) begin
      shadow_map_d = bus.codigo_map;
      shadow_atk_d = bus.codigo_atk;
      pend_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_map_q <= '0;
      shadow_atk_q <= '0;
      active_map_q <= '0;
      active_atk_q <= '0;
      pend_q       <= 1'b0;
    end else begin
      shadow_map_q <= shadow_map_d;
      shadow_atk_q <= shadow_atk_d;
      active_map_q <= active_map_d;
      active_atk_q <= active_atk_d;
      pend_q       <= pend_d;
    end
  end

  // Attack-layer gate
  logic atk_gate;

`ifdef MATRIZ_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          gate_q, gate_d;

  always_comb begin
    fcnt_d = fcnt_q;
    gate_d = gate_q;
    if (boundary) begin
      if (32'(fcnt_q) == BLINK_FRAMES - 1) begin
        fcnt_d = '0;
        gate_d = ~gate_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      gate_q <= 1'b1;
    end else begin
      fcnt_q <= fcnt_d;
      gate_q <= gate_d;
    end
  end

  assign atk_gate = gate_q;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_FRAMES;
  assign atk_gate     = 1'b1;
`endif

  // Mode mux and registered outputs
  modo_t           modo;
  logic [NROW-1:0] rows, linhas_d;
  logic [3:0]      col_sel_d;

  assign modo = !bus.ch7 ? MODE_OFF : (bus.ch6 ? MODE_MAP_ATK : MODE_MAP);

  always_comb begin
    rows = '0;
    unique case (modo)
      MODE_MAP:     rows = col_of(active_map_q, idx_q);
      MODE_MAP_ATK: rows = col_of(active_map_q, idx_q) |
                           (atk_gate ? col_of(active_atk_q, idx_q) : '0);
      default:      rows = '0;
    endcase
    linhas_d = in_blank ? '0 : rows;

    col_sel_d           = '0;
    col_sel_d[CS_IDX2]  = idx_q[2];
    col_sel_d[CS_IDX1]  = idx_q[1];
    col_sel_d[CS_IDX0]  = idx_q[0];
    col_sel_d[CS_BLANK] = in_blank;
  end

  logic [3:0]      col_sel_q;
  logic [NROW-1:0] linhas_q;
  logic            ativo_q, load_ack_q, frame_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sel_q     <= 4'b1000;
      linhas_q      <= '0;
      ativo_q       <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_sel_q     <= col_sel_d;
      linhas_q      <= linhas_d;
      ativo_q       <= bus.ch7;
      load_ack_q    <= commit;
      frame_start_q <= boundary;
    end
  end

  assign bus.col_sel     = col_sel_q;
  assign bus.linhas      = linhas_q;
  assign bus.ativo       = ativo_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule
